// File: rtl/clk_div_ctrl.sv
// Ratio-change controller for the shared programmable clock divider: arbitrates two requesters
// and applies each new ratio glitch-free. Define CLK_DIV_CTRL_RR_EN for round-robin arbitration.
module clk_div_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [4:0]  RESET_RATIO   = 5'd2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RUN,
    input  logic [1:0] REQ,
    input  logic [4:0] REQ_RATIO0,
    input  logic [4:0] REQ_RATIO1,
    output logic [1:0] ACK,
    output logic       ERR,
    output logic [4:0] DIV_RATIO,
    output logic       CLK_EN,
    output logic       BUSY,
    output logic       GRANT_ID
);

    typedef enum logic [1:0] {StIdle, StGate, StLoad, StAck} state_e;

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] new_ratio_q, new_ratio_d;
    logic [4:0] ratio_q, ratio_d;
    logic       clk_en_q, clk_en_d;
    logic       gid_q, gid_d;
    logic       err_q, err_d;

    logic [1:0] elig;
    logic       grant_valid;
    logic       grant_id;
    logic [4:0] grant_ratio;

`ifdef CLK_DIV_CTRL_RR_EN
    // Preferred requester on contention; flips away from whoever was granted last.
    logic rr_q, rr_d;
`endif

    always_comb begin
        ACK         = 2'b00;
        if (state_q == StAck) begin
            ACK = gid_q ? 2'b10 : 2'b01;
        end
        ERR         = (state_q == StAck) && err_q;
        BUSY        = (state_q != StIdle);
        DIV_RATIO   = ratio_q;
        CLK_EN      = clk_en_q;
        GRANT_ID    = gid_q;

        // A requester being acknowledged this cycle gets one cycle to drop REQ.
        elig        = REQ & ~ACK;
        grant_valid = |elig;
`ifdef CLK_DIV_CTRL_RR_EN
        grant_id    = (elig == 2'b11) ? rr_q : elig[1];
`else
        grant_id    = ~elig[0];
`endif
        grant_ratio = grant_id ? REQ_RATIO1 : REQ_RATIO0;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        new_ratio_d = new_ratio_q;
        ratio_d     = ratio_q;
        clk_en_d    = clk_en_q;
        gid_d       = gid_q;
        err_d       = err_q;
`ifdef CLK_DIV_CTRL_RR_EN
        rr_d        = rr_q;
`endif

        unique case (state_q)
            StIdle: begin
                clk_en_d = RUN;
                if (grant_valid) begin
                    gid_d       = grant_id;
                    new_ratio_d = grant_ratio;
`ifdef CLK_DIV_CTRL_RR_EN
                    rr_d        = ~grant_id;
`endif
                    if (grant_ratio == 5'd0) begin
                        err_d   = 1'b1;
                        state_d = StAck;
                    end else if (grant_ratio == ratio_q) begin
                        err_d   = 1'b0;
                        state_d = StAck;
                    end else begin
                        err_d    = 1'b0;
                        clk_en_d = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = StGate;
                    end
                end
            end
            StGate: begin
                clk_en_d = 1'b0;
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == SettleLast) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                ratio_d  = new_ratio_q;
                clk_en_d = RUN;
                state_d  = StAck;
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            new_ratio_q <= 5'd0;
            ratio_q     <= RESET_RATIO;
            clk_en_q    <= 1'b0;
            gid_q       <= 1'b0;
            err_q       <= 1'b0;
`ifdef CLK_DIV_CTRL_RR_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            new_ratio_q <= new_ratio_d;
            ratio_q     <= ratio_d;
            clk_en_q    <= clk_en_d;
            gid_q       <= gid_d;
            err_q       <= err_d;
`ifdef CLK_DIV_CTRL_RR_EN
            rr_q        <= rr_d;
`endif
        end
    end

endmodule
